lcm_unit: RTL
=============

# lcm_unit

Sequential least-common-multiple stage downstream of the subtraction-based GCD block. Takes the two 8-bit operands together with their GCD and computes lcm = (a / g) * b. It uses an 8-cycle restoring divider followed by an 8-cycle shift-add multiplier, with a start/busy/done handshake. The 16-bit result is held until the next accepted start.

## Interface
- No parameters; operand width fixed at 8 bits, result at 16 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  8  first operand; captured on accepted start.
- b  input  8  second operand; captured on accepted start.
- g  input  8  GCD of a and b (from the GCD stage); captured on accepted start.
- lcm  output  16  result register.
- done  output  1  one-cycle pulse when lcm/err are valid.
- busy  output  1  high while a computation is in progress.
- err  output  1  error flag; valid with done, held until next accepted start.

## Operation
- Reset values: lcm=0, done=0, busy=0, err=0, state=IDLE, all internal registers 0.
- States: IDLE, DIV, MUL, DONE.
- IDLE, start=1: capture a, b, g; clear err; go to DONE or DIV as follows.
  - a==0 or b==0: lcm=0, err=0, go to DONE (zero short-cut; g ignored).
  - Else g==0: lcm=0, err=1, go to DONE.
  - Else: go to DIV, step count 0.
- DIV: 8-bit restoring division of a by g, MSB first, one quotient bit per cycle.
  - 9-bit partial remainder.
  - After 8 steps: quotient q (8 bits), remainder r.
  - Then go to MUL.
- MUL: shift-add multiply q × b, one multiplier bit per cycle, 16-bit accumulator.
  - After 8 steps, load lcm with the product and go to DONE.
  - No overflow is possible: max 255×255 = 65025.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in DIV, MUL and DONE; 0 in IDLE.
- start while busy is ignored; no queuing. start held high in IDLE is accepted again on the cycle after DONE returns to IDLE.
- lcm and err hold their last values in IDLE. lcm changes only on load in MUL completion or on the DONE shortcuts.
- rst asserted in any state returns everything to reset values on that edge. The in-flight result is discarded and no done is produced.
- Input values a, b, g may change freely after the start edge; captured copies are used.

## Timing
- Start accepted at edge N.
- Normal path: DIV covers edges N+1..N+8, MUL covers N+9..N+16. lcm is valid and done=1 in the cycle after edge N+16, i.e. 17 cycles after acceptance.
- Zero or g==0 shortcut: done=1 in the cycle after edge N.
- Divisibility-check failure (see Configuration): done=1 in the cycle after edge N+8.
- Back-to-back: next start is accepted at the earliest one cycle after the done cycle.

## Configuration
- Macro: LCM_DIV_CHECK_EN.
- Defined:
  - At the end of DIV, a remainder r != 0 means g does not divide a. The block then sets err=1, lcm=0, skips MUL and goes to DONE, with done 9 cycles after acceptance.
  - If r==0 it continues normally.
- Undefined:
  - No remainder check; the remainder register may be omitted.
  - The quotient is used as computed, truncated toward zero.
  - err is set only by the g==0 case.

## Test plan
- Reset, then a=12, b=18, g=6, start for 1 cycle -> busy high for 17 cycles, then done pulse with lcm=36 and err=0. lcm still 36 ten cycles later.
- a=255, b=254, g=1 -> lcm=64770 (0xFD02), done at +17.
- a=0, b=5, g=5 -> lcm=0, err=0, done the cycle after acceptance. Then a=4, b=6, g=0 -> lcm=0, err=1, done the cycle after acceptance.
- a=12, b=18, g=5:
  - With LCM_DIV_CHECK_EN: err=1, lcm=0, done at +9.
  - Without: q=2, lcm=36, err=0, done at +17.
- Start a=12, b=18, g=6; pulse start again at +5 with a=7, b=7, g=7 -> second start ignored, lcm=36. Then start a=7, b=7, g=7 -> lcm=7.
- Start a=100, b=75, g=25; assert rst at +10 -> next edge lcm=0, busy=0, done never pulses. Re-run the same operands -> lcm=300.

Source files
------------

// File: rtl/lcm_unit.sv
// Sequential LCM stage: lcm = (a / g) * b via 8-cycle restoring divide then 8-cycle shift-add multiply.
// Optional remainder check (err when g does not divide a) enabled by LCM_DIV_CHECK_EN.
module lcm_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  g,
  output logic [15:0] lcm,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    dq;      // dividend shifts out the top while quotient shifts in the bottom
  logic [W:0]      rem;
  logic [W-1:0]    g_r;
  logic [RW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [RW-1:0]   acc;

  logic [W:0]      rem_sh;
  logic [W:0]      rem_nx;
  logic            q_bit;
  logic [W-1:0]    q_nx;
  logic [RW-1:0]   acc_nx;

  // One restoring-division step and one shift-add step.
  always_comb begin
    rem_sh = (W+1)'({rem, dq[W-1]});
    q_bit  = (rem_sh >= {1'b0, g_r});
    rem_nx = q_bit ? (rem_sh - {1'b0, g_r}) : rem_sh;
    q_nx   = {dq[W-2:0], q_bit};
    acc_nx = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dq     <= '0;
      rem    <= '0;
      g_r    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      lcm    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dq     <= a;
            g_r    <= g;
            mcand  <= RW'(b);
            mplier <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            busy   <= 1'b1;
            if (a == '0 || b == '0) begin
              lcm   <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else if (g == '0) begin
              lcm   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= DIV;
            end
          end
        end

        DIV: begin
          rem <= rem_nx;
          dq  <= q_nx;
          cnt <= CW'(cnt + 1'b1);
          if (cnt == CW'(W-1)) begin
`ifdef LCM_DIV_CHECK_EN
            if (rem_nx != '0) begin
              lcm   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mplier <= q_nx;
              acc    <= '0;
              state  <= MUL;
            end
`else
            mplier <= q_nx;
            acc    <= '0;
            state  <= MUL;
`endif
          end
        end

        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= CW'(cnt + 1'b1);
          if (cnt == CW'(W-1)) begin
            lcm   <= acc_nx;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
